// File: rtl/sine_ram_sched_pkg.sv
// Shared definitions for the sine-table RAM scheduler.
//   AW_DEF / DW_DEF / PW_DEF / HOST_MAX_DEF : default address, data, phase widths and host burst limit
//   owner_e  : which requester launched the read currently in flight
//   starve_w : width of the consecutive-host-grant counter
package sine_ram_sched_pkg;

    localparam int unsigned AW_DEF       = 8;
    localparam int unsigned DW_DEF       = 8;
    localparam int unsigned PW_DEF       = 16;
    localparam int unsigned HOST_MAX_DEF = 3;

    typedef enum logic {
        OWN_PLAY = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    // Counter must hold 0..host_max inclusive; never narrower than one bit.
    function automatic int unsigned starve_w(input int unsigned host_max);
        int unsigned w;
        w = $clog2(host_max + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// DDS phase accumulator feeding the sine-table read address.
//   clk, rst : clock, synchronous active-high reset
//   clr      : pulse, phase returns to zero (wins over adv)
//   adv      : playback slot taken, phase advances by inc
//   inc      : phase increment (PW bits, wraps modulo 2**PW)
//   addr     : top AW bits of the current phase, the table index
module sine_phase_acc #(
    parameter int unsigned AW = 8,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic [PW-1:0] inc,
    output logic [AW-1:0] addr
);

    logic [PW-1:0] phase;

    // The slot in progress always reads the pre-update phase; clr only affects the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (adv) begin
            phase <= phase + inc;
        end
    end

    assign addr = phase[PW-1 -: AW];

endmodule

// File: rtl/sine_ram_sched.sv
// Arbiter sharing one single-port sine-table RAM between DDS playback and a host port.
//   clk, rst                 : clock, synchronous active-high reset
//   run, phase_inc, phase_clr: playback control
//   host_req/we/addr/din     : host access request, granted on host_gnt in the same cycle
//   host_rvalid/host_rdata   : host read return, one cycle after the grant
//   smp_valid/smp_data       : playback sample, one cycle after the playback slot
//   ram_addr/we/din, ram_qout: single-port RAM interface (one-cycle read latency)
module sine_ram_sched
    import sine_ram_sched_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned PW       = PW_DEF,
    parameter int unsigned HOST_MAX = HOST_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [PW-1:0] phase_inc,
    input  logic          phase_clr,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_din,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          smp_valid,
    output logic [DW-1:0] smp_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_qout
);

    localparam int unsigned SW = starve_w(HOST_MAX);

    logic [SW-1:0] starve_cnt;
    logic          force_play;
    logic          play_slot;
    logic [AW-1:0] play_addr;
    logic          rd_valid;
    owner_e        rd_owner;

    // Slot arbitration: host first, unless it has used up its burst while playback runs.
    assign force_play = run && (starve_cnt == SW'(HOST_MAX));
    assign host_gnt   = host_req && !force_play && !rst;
    assign play_slot  = run && !host_gnt && !rst;

    sine_phase_acc #(
        .AW (AW),
        .PW (PW)
    ) u_phase_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (phase_clr),
        .adv  (play_slot),
        .inc  (phase_inc),
        .addr (play_addr)
    );

    // RAM port mux; host_gnt is already low in reset, so writes are blocked there too.
    always_comb begin
        ram_addr = play_addr;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (host_gnt) begin
            ram_addr = host_addr;
            ram_we   = host_we;
            ram_din  = host_din;
        end
    end

    // Consecutive host grants while playback is enabled; any playback slot or run=0 resets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!run || play_slot) begin
            starve_cnt <= '0;
        end else if (host_gnt && (starve_cnt != SW'(HOST_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Track who owns the read returning next cycle; host writes return nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_owner <= OWN_PLAY;
        end else begin
            rd_valid <= play_slot || (host_gnt && !host_we);
            rd_owner <= host_gnt ? OWN_HOST : OWN_PLAY;
        end
    end

    assign smp_valid   = rd_valid && (rd_owner == OWN_PLAY);
    assign host_rvalid = rd_valid && (rd_owner == OWN_HOST);

    // Gate data with its valid so both buses sit at zero out of reset and when idle.
    assign smp_data   = smp_valid   ? ram_qout : '0;
    assign host_rdata = host_rvalid ? ram_qout : '0;

endmodule

// File: doc/sine_ram_sched.md
Name: sine_ram_sched

Overview:
Scheduler that shares the single-port sine-table RAM (SpRamRfSine: addr, we, din, qout; synchronous read, one cycle latency) between two requesters.
- A built-in DDS playback engine: a phase accumulator that reads one sample per granted slot.
- A host port: table rewrite and readback with a req/gnt handshake.
- The host has priority; a starvation guard guarantees playback slots.
- Sits between the RAM instance and the waveform consumer and config master.

Parameters:
AW, 8, RAM address width (table depth 2**AW)
DW, 8, RAM data width
PW, 16, phase accumulator width (PW >= AW)
HOST_MAX, 3, max consecutive host grants while run=1 before one forced playback slot (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
run  in  1  playback enable
phase_inc  in  PW  phase increment per playback slot
phase_clr  in  1  pulse: phase := 0
host_req  in  1  host access request, held until host_gnt
host_we  in  1  1=write, 0=read (valid with host_req)
host_addr  in  AW  host address
host_din  in  DW  host write data
host_gnt  out  1  host access taken this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DW  host read data
smp_valid  out  1  playback sample valid
smp_data  out  DW  playback sample
ram_addr  out  AW  to RAM addr
ram_we  out  1  to RAM we
ram_din  out  DW  to RAM din
ram_qout  in  DW  from RAM qout

Behaviour:
- Slot arbitration is per cycle and combinational from registered state:
  - force_play = run && (starve_cnt == HOST_MAX).
  - host_gnt = host_req && !force_play && !rst.
  - play_slot = run && !host_gnt && !rst.
- RAM drive:
  - When host_gnt: ram_addr=host_addr, ram_we=host_we, ram_din=host_din.
  - Otherwise: ram_addr=phase[PW-1 -: AW], ram_we=0, ram_din=0.
  - ram_we is forced 0 while rst=1.
- starve_cnt (width clog2(HOST_MAX+1)):
  - Increments when host_gnt && run.
  - Clears to 0 on play_slot, or when run=0.
  - Never exceeds HOST_MAX.
- phase (PW bits):
  - phase_clr takes priority: phase := 0.
  - Else on play_slot: phase := phase + phase_inc, wrapping modulo 2**PW.
  - Else phase holds.
  - If phase_clr and play_slot occur together, the slot reads the old phase and the next phase is 0.
- Latency: one cycle.
  - smp_valid is a registered copy of play_slot; smp_data = ram_qout in the valid cycle.
  - host_rvalid is a registered copy of (host_gnt && !host_we); host_rdata = ram_qout.
  - Outputs are undefined (but stable) when their valid is 0.
- Write/read collision: a host write to the address playback would read takes the cycle. Playback reads the new data on its next slot (no bypass).
- run=0: no RAM reads except host accesses; the host is granted every requested cycle.
- run deasserted mid-stream: a sample already launched still produces its smp_valid next cycle.
- Reset values: phase=0, starve_cnt=0, smp_valid=0, host_rvalid=0, smp_data=0, host_rdata=0. host_gnt=0 and ram_we=0 during rst.
- Reset mid-operation:
  - In-flight read valids are dropped (smp_valid/host_rvalid are 0 the cycle after rst).
  - The host must re-request.
  - RAM contents are unaffected.

Decomposition:
- Package sine_ram_sched_pkg: default widths (AW, DW, PW), owner_e enum {OWN_PLAY, OWN_HOST} used for the registered last-owner/valid tracking, and a starve counter width function.
- One natural sub-module: sine_phase_acc (phase register, clr/inc/wrap, address slice).
- Arbitration and valid pipelining stay in the top.

Test Plan:
- Reset: hold rst 3 cycles with host_req=1, run=1 -> host_gnt=0, ram_we=0, smp_valid=0, host_rvalid=0. First cycle after release reads addr 0.
- Host write/read: run=0; write 8'h5A to 8'h03 (gnt same cycle, ram_we=1); then read 8'h03 -> host_rvalid=1 one cycle later, host_rdata=8'h5A.
- Playback: run=1, phase_inc=16'h0100, no host -> ram_addr 0,1,2,3... on consecutive cycles; smp_valid continuous from cycle 2; smp_data matches table entries 0,1,2....
- Starvation guard: run=1, host_req held for 12 cycles, HOST_MAX=3 -> grant pattern H,H,H,P repeating. Phase advances exactly once per P slot.
- Wrap/clear: phase at 16'hFF00, inc 16'h0100 -> next addr 8'h00. phase_clr together with a play slot -> that slot reads the old addr, then addr 0.
- Collision: playback about to read addr 8'h05, host writes 8'hEE to 8'h05 -> that cycle is host. The next playback slot returns 8'hEE.
